// File: rtl/conv_window_scheduler_if.sv
// Handshake and tag bundle between the window scheduler and its neighbours:
// the upstream pixel source, the 3x3 window buffer and the MAC engine.
interface conv_window_scheduler_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          buf_load_en;
  logic          buf_step_en;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_ch;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          first_ch;
  logic          last_ch;
  logic          busy;
  logic          done;

  // Job controller / pixel source / MAC side.
  modport master (
    output start, abort, in_valid, win_ready,
    input  in_ready, buf_load_en, buf_step_en, win_valid,
           win_ch, win_row, win_col, first_ch, last_ch, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, abort, in_valid, win_ready,
    output in_ready, buf_load_en, buf_step_en, win_valid,
           win_ch, win_row, win_col, first_ch, last_ch, busy, done
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Sequencer for the padded 3x3 window buffer: gates the pixel load, clocks
// the zero-padding pass, then steps out one tagged window per handshake.
module conv_window_scheduler #(
  parameter int CHANNEL = 2,
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int F_ROW   = 3,
  parameter int F_COL   = 3,
  parameter int CW      = 8,
  parameter int NW      = 20
) (
  input  logic                   clk,
  input  logic                   rst_,
  conv_window_scheduler_if.slave bus
);

  localparam int PIX  = CHANNEL * ROW * COL;
  localparam int PADN = CHANNEL * (ROW + F_ROW - 1) * (COL + F_COL - 1);

  localparam logic [NW-1:0] LOAD_LAST = NW'(PIX - 1);
  localparam logic [NW-1:0] PAD_LAST  = NW'(PADN - 1);
  localparam logic [NW-1:0] NW_ONE    = NW'(1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNEL - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COL - 1);
  localparam logic [CW-1:0] CW_ONE    = CW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state, state_n;
  logic [NW-1:0] load_cnt, pad_cnt;
  logic [CW-1:0] ch, row, col;
  logic [CW-1:0] ch_n, row_n, col_n;
  logic          in_ready_q, step_q, valid_q, first_q, last_q, busy_q, done_q;
  logic          beat, take, last_win;

  // The pixel strobe is the only combinational output so a pixel is written
  // in the same cycle the source offers it.
  assign beat            = in_ready_q & bus.in_valid;
  assign take            = (state == S_PRESENT) & bus.win_ready;
  assign last_win        = (ch == CH_LAST) && (row == ROW_LAST) && (col == COL_LAST);

  assign bus.buf_load_en = beat;
  assign bus.in_ready    = in_ready_q;
  assign bus.buf_step_en = step_q;
  assign bus.win_valid   = valid_q;
  assign bus.win_ch      = ch;
  assign bus.win_row     = row;
  assign bus.win_col     = col;
  assign bus.first_ch    = first_q;
  assign bus.last_ch     = last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // Next state; abort overrides every transition including start.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of inferred latches.
    state_n = state;
    case (state)
      S_IDLE:    if (bus.start) state_n = S_LOAD;
      S_LOAD:    if (beat && (load_cnt == LOAD_LAST)) state_n = S_PAD;
      S_PAD:     if (pad_cnt == PAD_LAST) state_n = S_ISSUE;
      S_ISSUE:   state_n = S_PRESENT;
      S_PRESENT: if (bus.win_ready) state_n = last_win ? S_DONE : S_ISSUE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (bus.abort) state_n = S_IDLE;
  end

  // Window coordinate advance on handshake: channel fastest, then column, then row.
  always_comb begin
    ch_n  = ch;
    row_n = row;
    col_n = col;
    if (take) begin
      if (ch != CH_LAST) begin
        ch_n = ch + CW_ONE;
      end else begin
        ch_n = '0;
        if (col != COL_LAST) begin
          col_n = col + CW_ONE;
        end else begin
          col_n = '0;
          row_n = (row == ROW_LAST) ? '0 : row + CW_ONE;
        end
      end
    end
  end

  // State, counters and registered outputs, all decoded from the next state.
  // NOTE: the asynchronous reset clears outputs immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= S_IDLE;
      load_cnt   <= '0;
      pad_cnt    <= '0;
      ch         <= '0;
      row        <= '0;
      col        <= '0;
      in_ready_q <= 1'b0;
      step_q     <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      load_cnt   <= (state_n != S_LOAD) ? '0 : (beat ? load_cnt + NW_ONE : load_cnt);
      pad_cnt    <= (state == S_PAD && state_n == S_PAD) ? pad_cnt + NW_ONE : '0;
      ch         <= (state_n == S_IDLE) ? '0 : ch_n;
      row        <= (state_n == S_IDLE) ? '0 : row_n;
      col        <= (state_n == S_IDLE) ? '0 : col_n;
      in_ready_q <= (state_n == S_LOAD);
      step_q     <= (state_n == S_PAD) || (state_n == S_ISSUE);
      valid_q    <= (state_n == S_PRESENT);
      // ch only moves on a handshake that leaves PRESENT, so it is the tag here.
      first_q    <= (state_n == S_PRESENT) && (ch == '0);
      last_q     <= (state_n == S_PRESENT) && (ch == CH_LAST);
      busy_q     <= (state_n != S_IDLE);
      done_q     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench: a driver issues jobs, the expected window sequence is
// computed from the tag formulas, and a negedge monitor checks every output.
module tb_conv_window_scheduler;

  localparam int CHANNEL = 2;
  localparam int ROW     = 4;
  localparam int COL     = 4;
  localparam int F_ROW   = 3;
  localparam int F_COL   = 3;
  localparam int CW      = 8;
  localparam int NW      = 20;
  localparam int PIX     = CHANNEL * ROW * COL;
  localparam int PADN    = CHANNEL * (ROW + F_ROW - 1) * (COL + F_COL - 1);

  typedef struct {
    int ch;
    int row;
    int col;
    bit first;
    bit last;
  } win_t;

  logic clk;
  logic rst_;
  conv_window_scheduler_if #(.CW(CW)) bus ();

  conv_window_scheduler #(
    .CHANNEL(CHANNEL), .ROW(ROW), .COL(COL), .F_ROW(F_ROW), .F_COL(F_COL),
    .CW(CW), .NW(NW)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   errors = 0;
  win_t exp_q[$];

  bit   mon_en = 0;
  int   beats, in_ready_cyc, step_cyc, pre_step, taken, fcnt, lcnt, done_cnt, stall_cyc;
  bit   win_seen;
  int   bp_mode = 0;
  int   stall_drv;
  bit   prev_valid, prev_ready, prev_done;
  logic [3*CW-1:0] prev_tags;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    beats = 0; in_ready_cyc = 0; step_cyc = 0; pre_step = 0; taken = 0;
    fcnt = 0; lcnt = 0; done_cnt = 0; stall_cyc = 0; stall_drv = 0;
    win_seen = 0; prev_valid = 0; prev_ready = 0; prev_done = 0; prev_tags = '0;
  endtask

  // Reference window order straight from the tag formulas.
  task automatic build_expected();
    win_t w;
    exp_q.delete();
    for (int k = 0; k < PIX; k++) begin
      w.ch    = k % CHANNEL;
      w.col   = (k / CHANNEL) % COL;
      w.row   = k / (CHANNEL * COL);
      w.first = (w.ch == 0);
      w.last  = (w.ch == CHANNEL - 1);
      exp_q.push_back(w);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.in_ready)    in_ready_cyc++;
      if (bus.buf_load_en) beats++;
      if (bus.buf_step_en) begin
        if (step_cyc == 0) check("pad_starts_after_load", beats, PIX);
        step_cyc++;
        if (!win_seen) pre_step++;
        check("no_step_while_valid", bus.win_valid, 0);
      end
      if (bus.win_valid) win_seen = 1;
      if (prev_valid && !prev_ready) begin
        stall_cyc++;
        check("hold_valid", bus.win_valid, 1);
        check("hold_tags", {bus.win_ch, bus.win_row, bus.win_col}, prev_tags);
      end
      if (bus.win_valid && bus.win_ready) begin
        check("window_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          win_t w;
          w = exp_q.pop_front();
          check("win_ch", bus.win_ch, w.ch);
          check("win_row", bus.win_row, w.row);
          check("win_col", bus.win_col, w.col);
          check("first_ch", bus.first_ch, w.first);
          check("last_ch", bus.last_ch, w.last);
        end
        taken++;
        if (bus.first_ch) fcnt++;
        if (bus.last_ch)  lcnt++;
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_during_done", bus.busy, 1);
      end
      if (prev_done) check("busy_after_done", bus.busy, 0);
      prev_valid = bus.win_valid;
      prev_ready = bus.win_ready;
      prev_done  = bus.done;
      prev_tags  = {bus.win_ch, bus.win_row, bus.win_col};
    end
  end

  // Downstream ready driver; the mode selects the backpressure pattern.
  initial begin
    bus.win_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: bus.win_ready = 1'b1;
        1: bus.win_ready = 1'($urandom_range(0, 1));
        2: if (bus.win_valid && taken == 3 && stall_drv < 5) begin
             bus.win_ready = 1'b0;
             stall_drv++;
           end else begin
             bus.win_ready = 1'b1;
           end
        3: bus.win_ready = (taken < 5);
        default: bus.win_ready = 1'b0;
      endcase
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  // vmode 0: continuous, 1: every other cycle, 2: random. in_valid is held
  // high a few cycles past the last beat to show no extra pixels get in.
  task automatic load_pixels(input int vmode, input bit restart);
    int cyc = 0;
    while (beats < PIX && cyc < 2000) begin
      bus.in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      bus.start    = (restart && cyc == 5);
      cycle();
      cyc++;
    end
    bus.start = 1'b0;
    check("load_completed", beats >= PIX, 1);
    bus.in_valid = 1'b1;
    repeat (4) cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input int vmode, input int bmode, input bit restart);
    int cyc = 0;
    clear_stats();
    build_expected();
    bp_mode = bmode;
    mon_en  = 1;
    pulse_start();
    load_pixels(vmode, restart);
    while (done_cnt == 0 && cyc < 5000) begin
      cycle();
      cyc++;
    end
    check("job_done_in_time", done_cnt != 0, 1);
    repeat (4) cycle();
    check("load_beats", beats, PIX);
    check("windows_taken", taken, PIX);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pad_then_issue_len", pre_step, PADN + 1);
    check("step_total", step_cyc, PADN + PIX);
    check("done_pulses", done_cnt, 1);
    check("first_ch_count", fcnt, PIX / CHANNEL);
    check("last_ch_count", lcnt, PIX / CHANNEL);
    check("idle_after_job", bus.busy, 0);
    if (vmode == 0) check("in_ready_cycles", in_ready_cyc, PIX);
    if (bmode == 0) check("no_stalls", stall_cyc, 0);
    if (bmode == 2) check("stall_cycles", stall_cyc, 5);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_load_en"}, bus.buf_load_en, 0);
    check({tag, "_step_en"}, bus.buf_step_en, 0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_tags"}, {bus.win_ch, bus.win_row, bus.win_col}, 0);
    check({tag, "_first_last"}, {bus.first_ch, bus.last_ch}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    check_all_idle("reset");
    rst_ = 1'b1;
    cycle();

    run_job(0, 0, 0);
    run_job(1, 1, 0);
    run_job(2, 2, 1);

    // Abort in the middle of the padding pass.
    clear_stats();
    mon_en = 1;
    bp_mode = 0;
    pulse_start();
    load_pixels(0, 0);
    cyc = 0;
    while (step_cyc < 40 && cyc < 500) begin
      cycle();
      cyc++;
    end
    check("reached_pad_40", step_cyc, 40);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    @(negedge clk);
    check_all_idle("abort");
    repeat (10) cycle();
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", bus.busy, 0);

    // start together with abort in IDLE is a no-op.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_in_ready", bus.in_ready, 0);
    repeat (3) cycle();
    check("start_abort_still_idle", bus.busy, 0);

    // A fresh job right after abort must take a full frame of pixels.
    run_job(2, 1, 0);

    // Asynchronous reset while a window is held under backpressure.
    clear_stats();
    build_expected();
    mon_en = 1;
    bp_mode = 3;
    pulse_start();
    load_pixels(0, 0);
    cyc = 0;
    while (!(bus.win_valid && taken == 5) && cyc < 1000) begin
      cycle();
      cyc++;
    end
    check("held_window_reached", bus.win_valid && taken == 5, 1);
    check("held_window_tags", {bus.win_ch, bus.win_row, bus.win_col},
          {8'd1, 8'd0, 8'd2});
    mon_en = 0;
    #2 rst_ = 1'b0;
    #1;
    check("async_rst_win_valid", bus.win_valid, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_tags", {bus.win_ch, bus.win_row, bus.win_col}, 0);
    #2 rst_ = 1'b1;
    cycle();
    @(negedge clk);
    check_all_idle("post_reset");
    cycle();

    run_job(0, 0, 0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
